doppler_sequencer: RTL and testbench

Pulse-repetition sequencer for the ultrasound Doppler front end. It decodes register writes (register address plus 16-bit value) from the SPI communication layer into a shadowed configuration set. For each pulse-repetition period it then generates the transmit burst, the receive gate, the demodulation window and the frame marker.

---
 rtl/doppler_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_doppler_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/doppler_sequencer.sv
// Ultrasound Doppler pulse-repetition sequencer: shadowed register decode plus TX/RX/demod window generation.
// Optional FrameCount output is enabled by defining SEQ_FRAME_COUNT_EN.
module doppler_sequencer #(
  parameter logic [7:0] CMD_DELAY1     = 8'h10,
  parameter logic [7:0] CMD_DEMOD      = 8'h11,
  parameter logic [7:0] CMD_DELAY2     = 8'h12,
  parameter logic [7:0] CMD_RETRANSMIT = 8'h13,
  parameter logic [7:0] CMD_SETTINGS   = 8'h14
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [7:0]  Reg,
  input  logic [15:0] RegValue,
  input  logic        RegValid,
  output logic        TX_P,
  output logic        TX_N,
  output logic        RX_GATE,
  output logic        DEMOD_EN,
  output logic [2:0]  RX_GAIN,
  output logic        FrameDone,
  output logic        Busy,
  output logic        CfgErr,
  output logic        DbgState
`ifdef SEQ_FRAME_COUNT_EN
  ,
  output logic [15:0] FrameCount
`endif
);

  // Handshake: RegValid is a one-cycle strobe with no back-pressure; Reg and
  // RegValue are sampled on the rising CLK edge where RegValid is high.

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [15:0] t_q, t_d;

  logic [15:0] sh_delay1_q, sh_demod_q, sh_delay2_q, sh_retx_q, sh_settings_q;

  logic [15:0] act_delay1_q, act_demod_q, act_delay2_q, act_retx_q;
  logic [7:0]  act_ncyc_q;
  logic [1:0]  act_fsel_q;
  logic        act_inv_q, act_cont_q;

  logic        load, clr_run, err_set, err_clr;
  logic        sh_run, sh_cont, sh_retx_ok, last_cycle;

  logic        tx_p_q, tx_n_q, rx_gate_q, demod_q, done_q, busy_q, cfg_err_q;
  logic        tx_p_d, tx_n_d, rx_gate_d, demod_d, done_d, busy_d;
  logic [15:0] burst_len;
  logic        half, tx_on;

  assign sh_run     = sh_settings_q[0];
  assign sh_cont    = sh_settings_q[1];
  assign sh_retx_ok = (sh_retx_q >= 16'd2);
  assign last_cycle = (t_q == 16'(act_retx_q - 16'd1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sh_delay1_q   <= '0;
      sh_demod_q    <= '0;
      sh_delay2_q   <= '0;
      sh_retx_q     <= '0;
      sh_settings_q <= '0;
    end else begin
      if (RegValid) begin
        case (Reg)
          CMD_DELAY1:     sh_delay1_q   <= RegValue;
          CMD_DEMOD:      sh_demod_q    <= RegValue;
          CMD_DELAY2:     sh_delay2_q   <= RegValue;
          CMD_RETRANSMIT: sh_retx_q     <= RegValue;
          CMD_SETTINGS:   sh_settings_q <= RegValue;
          default: ;
        endcase
      end
      // A host write to the settings register in the same cycle wins over the single-shot clear.
      if (clr_run && !(RegValid && (Reg == CMD_SETTINGS)))
        sh_settings_q[0] <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    load    = 1'b0;
    clr_run = 1'b0;
    err_set = 1'b0;
    err_clr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sh_run) begin
          if (sh_retx_ok) begin
            load    = 1'b1;
            err_clr = 1'b1;
            t_d     = '0;
            state_d = S_RUN;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (last_cycle) begin
          t_d = '0;
          if (sh_run && (sh_cont || act_cont_q) && sh_retx_ok) begin
            load = 1'b1;
          end else begin
            state_d = S_IDLE;
            clr_run = !act_cont_q;
            err_set = sh_run && !sh_retx_ok;
          end
        end else begin
          t_d = t_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      act_delay1_q <= '0;
      act_demod_q  <= '0;
      act_delay2_q <= '0;
      act_retx_q   <= '0;
      act_ncyc_q   <= '0;
      act_fsel_q   <= '0;
      act_inv_q    <= 1'b0;
      act_cont_q   <= 1'b0;
    end else if (load) begin
      act_delay1_q <= sh_delay1_q;
      act_demod_q  <= sh_demod_q;
      act_delay2_q <= sh_delay2_q;
      act_retx_q   <= sh_retx_q;
      act_ncyc_q   <= sh_settings_q[13:6];
      act_fsel_q   <= sh_settings_q[15:14];
      act_inv_q    <= sh_settings_q[2];
      act_cont_q   <= sh_settings_q[1];
    end
  end

  // Carrier divider D = 64 >> FSEL; the half-period bit of t selects the P or N phase.
  always_comb begin
    burst_len = {8'd0, act_ncyc_q} << (3'd6 - {1'b0, act_fsel_q});
    case (act_fsel_q)
      2'd0:    half = t_q[5];
      2'd1:    half = t_q[4];
      2'd2:    half = t_q[3];
      default: half = t_q[2];
    endcase
    busy_d    = (state_q == S_RUN);
    tx_on     = busy_d && (t_q < burst_len);
    tx_p_d    = tx_on && (act_inv_q ? half : !half);
    tx_n_d    = tx_on && (act_inv_q ? !half : half);
    rx_gate_d = busy_d && (t_q >= act_delay1_q) && (t_q < act_delay2_q);
    demod_d   = busy_d && (t_q >= act_demod_q) && (t_q < act_delay2_q);
    done_d    = busy_d && last_cycle;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tx_p_q    <= 1'b0;
      tx_n_q    <= 1'b0;
      rx_gate_q <= 1'b0;
      demod_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      tx_p_q    <= tx_p_d;
      tx_n_q    <= tx_n_d;
      rx_gate_q <= rx_gate_d;
      demod_q   <= demod_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      if (err_clr)      cfg_err_q <= 1'b0;
      else if (err_set) cfg_err_q <= 1'b1;
    end
  end

`ifdef SEQ_FRAME_COUNT_EN
  logic [15:0] frame_cnt_q;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)      frame_cnt_q <= '0;
    else if (done_q) frame_cnt_q <= frame_cnt_q + 16'd1;
  end
  assign FrameCount = frame_cnt_q;
`endif

  assign TX_P      = tx_p_q;
  assign TX_N      = tx_n_q;
  assign RX_GATE   = rx_gate_q;
  assign DEMOD_EN  = demod_q;
  assign RX_GAIN   = sh_settings_q[5:3];
  assign FrameDone = done_q;
  assign Busy      = busy_q;
  assign CfgErr    = cfg_err_q;
  assign DbgState  = state_q;

endmodule

// File: tb/tb_doppler_sequencer.sv
// Self-checking bench for doppler_sequencer: per-period window statistics are
// measured from the outputs and compared against an expected-period queue.
`timescale 1ns/1ps
module tb_doppler_sequencer;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [7:0]  Reg = '0;
  logic [15:0] RegValue = '0;
  logic        RegValid = 1'b0;
  logic        TX_P, TX_N, RX_GATE, DEMOD_EN, FrameDone, Busy, CfgErr, DbgState;
  logic [2:0]  RX_GAIN;
`ifdef SEQ_FRAME_COUNT_EN
  logic [15:0] FrameCount;
`endif

  doppler_sequencer dut (
    .CLK(CLK), .RST_N(RST_N), .Reg(Reg), .RegValue(RegValue), .RegValid(RegValid),
    .TX_P(TX_P), .TX_N(TX_N), .RX_GATE(RX_GATE), .DEMOD_EN(DEMOD_EN),
    .RX_GAIN(RX_GAIN), .FrameDone(FrameDone), .Busy(Busy), .CfgErr(CfgErr),
    .DbgState(DbgState)
`ifdef SEQ_FRAME_COUNT_EN
    , .FrameCount(FrameCount)
`endif
  );

  // ---------------- clock / reset ----------------
  always #8 CLK = ~CLK;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  localparam int NONE = 65535;
  int n_tests = 0;
  int n_fail  = 0;
  logic [159:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // fields: len, p_cnt, n_cnt, p_rise, p_first, rx_first, rx_cnt, dm_first, dm_cnt, overlap
  task automatic push_exp(input int len, input int pc, input int nc, input int rise, input int pf,
                          input int rxf, input int rxc, input int dmf, input int dmc);
    exp_q.push_back({16'(len), 16'(pc), 16'(nc), 16'(rise), 16'(pf),
                     16'(rxf), 16'(rxc), 16'(dmf), 16'(dmc), 16'd0});
  endtask

  int m_len, m_pc, m_nc, m_rise, m_pf, m_rxf, m_rxc, m_dmf, m_dmc, m_ovl;
  logic prev_p;
  int frames_after_reset;

  task automatic mon_clear();
    m_len = 0; m_pc = 0; m_nc = 0; m_rise = 0; m_pf = NONE;
    m_rxf = NONE; m_rxc = 0; m_dmf = NONE; m_dmc = 0; m_ovl = 0;
  endtask

  initial begin
    logic [159:0] e;
    mon_clear();
    prev_p = 1'b0;
    frames_after_reset = 0;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        mon_clear();
        prev_p = 1'b0;
        frames_after_reset = 0;
      end else begin
        if (Busy) begin
          if (TX_P) begin
            m_pc++;
            if (!prev_p) m_rise++;
            if (m_pf == NONE) m_pf = m_len;
          end
          if (TX_N) m_nc++;
          if (TX_P && TX_N) m_ovl++;
          if (RX_GATE) begin
            m_rxc++;
            if (m_rxf == NONE) m_rxf = m_len;
          end
          if (DEMOD_EN) begin
            m_dmc++;
            if (m_dmf == NONE) m_dmf = m_len;
          end
          m_len++;
        end
        prev_p = TX_P;
        if (FrameDone) begin
          frames_after_reset++;
          check("frame_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("period_len", m_len, e[159:144]);
            check("tx_p_cycles", m_pc, e[143:128]);
            check("tx_n_cycles", m_nc, e[127:112]);
            check("tx_p_rises", m_rise, e[111:96]);
            check("tx_p_first", m_pf, e[95:80]);
            check("rx_gate_first", m_rxf, e[79:64]);
            check("rx_gate_cycles", m_rxc, e[63:48]);
            check("demod_first", m_dmf, e[47:32]);
            check("demod_cycles", m_dmc, e[31:16]);
            check("tx_overlap", m_ovl, e[15:0]);
          end
          mon_clear();
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic write_reg(input logic [7:0] addr, input logic [15:0] val);
    @(posedge CLK); #1;
    Reg = addr; RegValue = val; RegValid = 1'b1;
    @(posedge CLK); #1;
    RegValid = 1'b0;
  endtask

  task automatic wait_frame(input string tag, input int max_cycles);
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!FrameDone && n < max_cycles);
    if (!FrameDone) check({"timeout_", tag}, 0, 1);
  endtask

  task automatic count_busy(input string tag, input int cycles);
    int b;
    b = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge CLK);
      if (Busy || TX_P || TX_N || RX_GATE || DEMOD_EN) b++;
    end
    check(tag, b, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_tx_p", TX_P, 0);
    check("rst_tx_n", TX_N, 0);
    check("rst_rx_gate", RX_GATE, 0);
    check("rst_demod", DEMOD_EN, 0);
    check("rst_gain", RX_GAIN, 0);
    check("rst_frame", FrameDone, 0);
    check("rst_busy", Busy, 0);
    check("rst_cfgerr", CfgErr, 0);
    check("rst_state", DbgState, 0);
    RST_N = 1'b1;

    // Continuous run, NCYC=8, FSEL=1 (D=32), gain 5.
    write_reg(8'h10, 16'd100);
    write_reg(8'h11, 16'd3000);
    write_reg(8'h12, 16'd4056);
    write_reg(8'h13, 16'd6400);
    push_exp(6400, 128, 128, 8, 0, 100, 3956, 3000, 1056);
    write_reg(8'h14, 16'd16939);
    check("gain_immediate", RX_GAIN, 5);
    @(posedge CLK); #1;
    check("busy_k2", Busy, 0);
    check("state_k2", DbgState, 1);
    @(posedge CLK); #1;
    check("tx_p_k3", TX_P, 1);
    check("busy_k3", Busy, 1);

    // DELAY1 change mid-period applies to the next period only.
    repeat (1000) @(posedge CLK);
    write_reg(8'h10, 16'd200);
    push_exp(6400, 128, 128, 8, 0, 200, 3856, 3000, 1056);
    wait_frame("p1", 7000);
    repeat (100) @(posedge CLK);
    write_reg(8'h14, 16'd16938);
    wait_frame("p2", 7000);
    @(posedge CLK); #1;
    check("stop_busy", Busy, 0);
    check("stop_state", DbgState, 0);

    // Single shot.
    push_exp(6400, 128, 128, 8, 0, 200, 3856, 3000, 1056);
    write_reg(8'h14, 16'd16937);
    wait_frame("single", 7000);
    @(posedge CLK); #1;
    check("single_busy", Busy, 0);
    count_busy("single_quiet", 300);

    // RETRANSMIT below 2 is rejected.
    write_reg(8'h13, 16'd1);
    write_reg(8'h14, 16'd16939);
    repeat (4) @(posedge CLK); #1;
    check("cfgerr_set", CfgErr, 1);
    check("cfgerr_busy", Busy, 0);
    write_reg(8'h13, 16'd6400);
    repeat (3) @(posedge CLK); #1;
    check("cfgerr_clear", CfgErr, 0);
    check("cfgerr_start", Busy, 1);

    // Asynchronous reset around t = 1500.
    repeat (1496) @(posedge CLK);
    #3;
    check("pre_reset_busy", Busy, 1);
    RST_N = 1'b0;
    #1;
    check("arst_tx", {TX_P, TX_N}, 0);
    check("arst_rx", {RX_GATE, DEMOD_EN}, 0);
    check("arst_busy", Busy, 0);
    check("arst_gain", RX_GAIN, 0);
    exp_q.delete();
    repeat (2) @(posedge CLK);
    #4;
    RST_N = 1'b1;
    count_busy("post_reset_quiet", 200);
    check("post_reset_cfgerr", CfgErr, 0);

    // Truncated burst: NCYC=255, FSEL=0, RETRANSMIT=1000; windows 0..0 never assert.
    write_reg(8'h13, 16'd1000);
    push_exp(1000, 512, 488, 16, 0, NONE, 0, NONE, 0);
    write_reg(8'h14, 16'd16321);
    wait_frame("trunc", 1100);
    check("trunc_last_n", TX_N, 1);
    check("trunc_last_p", TX_P, 0);
    @(posedge CLK); #1;
    check("trunc_after", {TX_P, TX_N}, 0);
    check("trunc_busy", Busy, 0);

    // TX_INVERT, NCYC=1, FSEL=3 (D=8); DEMOD beyond DELAY2 never asserts.
    write_reg(8'h10, 16'd10);
    write_reg(8'h12, 16'd20);
    write_reg(8'h11, 16'd30);
    write_reg(8'h13, 16'd100);
    push_exp(100, 4, 4, 1, 4, 10, 10, NONE, 0);
    write_reg(8'h14, 16'd49221);
    wait_frame("invert", 200);
    repeat (3) @(posedge CLK); #1;
    check("invert_idle", Busy, 0);
    check("frames_after_reset", frames_after_reset, 2);
`ifdef SEQ_FRAME_COUNT_EN
    check("frame_count", FrameCount, 2);
`endif
    check("exp_queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
